// File: rtl/knn_pkg.sv
// Shared types and constants for the k-nearest-neighbour top-K sorter.
package knn_pkg;

  localparam int KNN_DIST_W = 18;
  localparam int KNN_IDX_W  = 10;
  localparam int KNN_K      = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2
  } state_t;

  typedef struct packed {
    logic                  filled;
    logic [KNN_DIST_W-1:0] distance;
    logic [KNN_IDX_W-1:0]  index;
  } slot_t;

  // An empty slot sits at the farthest possible distance.
  localparam logic [KNN_DIST_W-1:0] EMPTY_DIST = '1;
  localparam slot_t EMPTY_SLOT = '{filled: 1'b0, distance: EMPTY_DIST, index: '0};

endpackage

// File: rtl/knn_sort_cell.sv
// One slot of the sorted insertion register. A slot takes the upstream
// entry when the new sample was inserted above it (shift down), otherwise
// takes the new sample when it is empty or strictly farther away.
module knn_sort_cell
  import knn_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  clr,
  input  logic  ins_en,
  input  slot_t new_entry,
  input  slot_t up_entry,
  input  logic  up_ins,
  output slot_t entry,
  output logic  ins_out
);

  logic qualify;

  // Strict less-than keeps the earlier sample ahead on ties.
  always_comb begin
    qualify = !entry.filled || (new_entry.distance < entry.distance);
    ins_out = up_ins || qualify;
  end

  // Slot register: cleared by reset or query start, updated on insertion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      entry <= EMPTY_SLOT;
    end else if (clr) begin
      entry <= EMPTY_SLOT;
    end else if (ins_en) begin
      if (up_ins) begin
        entry <= up_entry;
      end else if (qualify) begin
        entry <= new_entry;
      end
    end
  end

endmodule

// File: rtl/knn_topk_sorter.sv
// Keeps the K smallest distances of a query in a sorted slot chain and
// streams them out in rank order once NUM_TRAIN samples have arrived.
module knn_topk_sorter
  import knn_pkg::*;
#(
  parameter int K         = KNN_K,
  parameter int NUM_TRAIN = 1024,
  parameter int DIST_W    = KNN_DIST_W,
  parameter int IDX_W     = KNN_IDX_W,
  localparam int RANK_W   = (K > 1) ? $clog2(K) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIST_W-1:0] distance,
  input  logic              valid,
  output logic              busy,
  output logic              out_valid,
  output logic [RANK_W-1:0] out_rank,
  output logic [IDX_W-1:0]  out_index,
  output logic [DIST_W-1:0] out_distance,
  output logic              out_filled,
  output logic              done
);

  // Drain counter runs 0..K; the value K is the done cycle.
  localparam int DCNT_W = $clog2(K + 1);

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    cnt_q;
  logic [DCNT_W-1:0]   dcnt_q;
  logic                accept, last, drain_end;
  slot_t               new_entry, sel_entry;
  slot_t               entry    [K];
  slot_t               up_entry [K];
  logic                ins_chain [K+1];

  assign accept    = (state_q == ST_COLLECT) && valid && !start;
  assign last      = accept && (cnt_q == IDX_W'(NUM_TRAIN - 1));
  assign drain_end = (state_q == ST_DRAIN) && (dcnt_q == DCNT_W'(K));
  assign busy      = (state_q != ST_IDLE);
  assign new_entry = '{filled: 1'b1, distance: distance, index: cnt_q};
  assign ins_chain[0] = 1'b0;

  // Slot chain: cell 0 is the nearest neighbour; ins_chain[K] flags that
  // the new sample lands somewhere in the list at all.
  for (genvar g = 0; g < K; g++) begin : g_cell
    if (g == 0) begin : g_head
      assign up_entry[g] = new_entry;
    end else begin : g_body
      assign up_entry[g] = entry[g-1];
    end
    knn_sort_cell u_cell (
      .clk       (clk),
      .rst       (rst),
      .clr       (start),
      .ins_en    (accept && ins_chain[K]),
      .new_entry (new_entry),
      .up_entry  (up_entry[g]),
      .up_ins    (ins_chain[g]),
      .entry     (entry[g]),
      .ins_out   (ins_chain[g+1])
    );
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; start restarts the query from any state.
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = ST_COLLECT;
    end else begin
      unique case (state_q)
        ST_IDLE:    state_d = ST_IDLE;
        ST_COLLECT: if (last) state_d = ST_DRAIN;
        ST_DRAIN:   if (drain_end) state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // Sample index counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        cnt_q <= '0;
    else if (start)  cnt_q <= '0;
    else if (accept) cnt_q <= cnt_q + 1'b1;
  end

  // Drain rank counter, held at zero outside DRAIN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                 dcnt_q <= '0;
    else if (start || state_q != ST_DRAIN)    dcnt_q <= '0;
    else if (!drain_end)                      dcnt_q <= dcnt_q + 1'b1;
  end

  // Select the slot addressed by the drain counter.
  always_comb begin
    sel_entry = EMPTY_SLOT;
    for (int i = 0; i < K; i++) begin
      if (dcnt_q == DCNT_W'(i)) sel_entry = entry[i];
    end
  end

  // Registered output stream and done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid    <= 1'b0;
      out_rank     <= '0;
      out_index    <= '0;
      out_distance <= '0;
      out_filled   <= 1'b0;
      done         <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      done      <= 1'b0;
      if (!start && state_q == ST_DRAIN) begin
        if (drain_end) begin
          done <= 1'b1;
        end else begin
          out_valid    <= 1'b1;
          out_rank     <= dcnt_q[RANK_W-1:0];
          out_index    <= sel_entry.index;
          out_distance <= sel_entry.distance;
          out_filled   <= sel_entry.filled;
        end
      end
    end
  end

endmodule

// File: tb/tb_knn_topk_sorter.sv
// Directed bench for knn_topk_sorter: one instance with NUM_TRAIN=8 and one
// with NUM_TRAIN=2, both K=4.
module tb_knn_topk_sorter;
  import knn_pkg::*;

  localparam int K  = 4;
  localparam int DW = 18;
  localparam int IW = 10;
  localparam int RW = 2;
  localparam logic [DW-1:0] ONES = '1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic          start8 = 1'b0, valid8 = 1'b0;
  logic [DW-1:0] dist8  = '0;
  logic          busy8, ovalid8, ofilled8, done8;
  logic [RW-1:0] orank8;
  logic [IW-1:0] oidx8;
  logic [DW-1:0] odist8;

  logic          start2 = 1'b0, valid2 = 1'b0;
  logic [DW-1:0] dist2  = '0;
  logic          busy2, ovalid2, ofilled2, done2;
  logic [RW-1:0] orank2;
  logic [IW-1:0] oidx2;
  logic [DW-1:0] odist2;

  knn_topk_sorter #(.K(K), .NUM_TRAIN(8), .DIST_W(DW), .IDX_W(IW)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .distance(dist8), .valid(valid8),
    .busy(busy8), .out_valid(ovalid8), .out_rank(orank8), .out_index(oidx8),
    .out_distance(odist8), .out_filled(ofilled8), .done(done8)
  );

  knn_topk_sorter #(.K(K), .NUM_TRAIN(2), .DIST_W(DW), .IDX_W(IW)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .distance(dist2), .valid(valid2),
    .busy(busy2), .out_valid(ovalid2), .out_rank(orank2), .out_index(oidx2),
    .out_distance(odist2), .out_filled(ofilled2), .done(done2)
  );

  always #5 clk = ~clk;

  // Observation mux: sel2 picks which instance the drain task watches.
  logic          sel2 = 1'b0;
  logic          o_valid, o_busy, o_done, o_filled;
  logic [RW-1:0] o_rank;
  logic [IW-1:0] o_idx;
  logic [DW-1:0] o_dist;
  always_comb begin
    o_valid  = sel2 ? ovalid2  : ovalid8;
    o_busy   = sel2 ? busy2    : busy8;
    o_done   = sel2 ? done2    : done8;
    o_filled = sel2 ? ofilled2 : ofilled8;
    o_rank   = sel2 ? orank2   : orank8;
    o_idx    = sel2 ? oidx2    : oidx8;
    o_dist   = sel2 ? odist2   : odist8;
  end

  int checks = 0;
  int errors = 0;
  int lat;
  logic [DW-1:0] got_d [K];
  logic [IW-1:0] got_i [K];
  logic          got_f [K];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // All drive tasks are entered at a falling edge and leave at one.
  task automatic start_q(input bit u);
    if (u) start2 = 1'b1; else start8 = 1'b1;
    @(negedge clk);
    start2 = 1'b0; start8 = 1'b0;
  endtask

  task automatic send(input bit u, input logic [DW-1:0] d, input int gap);
    if (u) begin valid2 = 1'b1; dist2 = d; end
    else   begin valid8 = 1'b1; dist8 = d; end
    @(negedge clk);
    valid2 = 1'b0; valid8 = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic drain(input bit u, input string tag);
    sel2 = u;
    lat = 0;
    #1;
    while (!o_valid && lat < 20) begin @(negedge clk); lat++; end
    check({tag, "_seen"}, o_valid, 1'b1);
    for (int r = 0; r < K; r++) begin
      check($sformatf("%s_valid%0d", tag, r), o_valid, 1'b1);
      check($sformatf("%s_rank%0d", tag, r), o_rank, r);
      got_d[r] = o_dist; got_i[r] = o_idx; got_f[r] = o_filled;
      @(negedge clk);
    end
    check({tag, "_done"}, o_done, 1'b1);
    check({tag, "_busy_done"}, o_busy, 1'b0);
    check({tag, "_valid_done"}, o_valid, 1'b0);
    @(negedge clk);
    check({tag, "_done_pulse"}, o_done, 1'b0);
  endtask

  task automatic expect_entry(input string tag, input int r, input logic [DW-1:0] d,
                              input logic [IW-1:0] i, input logic f);
    check($sformatf("%s_d%0d", tag, r), got_d[r], d);
    check($sformatf("%s_i%0d", tag, r), got_i[r], i);
    check($sformatf("%s_f%0d", tag, r), got_f[r], f);
  endtask

  // Expected top-4 of the reference vector 50,20,70,20,10,90,30,5.
  task automatic expect_ref(input string tag);
    expect_entry(tag, 0, 5,  7, 1'b1);
    expect_entry(tag, 1, 10, 4, 1'b1);
    expect_entry(tag, 2, 20, 1, 1'b1);
    expect_entry(tag, 3, 20, 3, 1'b1);
  endtask

  logic [DW-1:0] ref_vec [8] = '{50, 20, 70, 20, 10, 90, 30, 5};

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", busy8, 1'b0);
    check("rst_valid", ovalid8, 1'b0);
    check("rst_done", done8, 1'b0);
    check("rst_dist", odist8, 0);
    check("rst_slot_dist", dut8.entry[0].distance, ONES);
    rst = 1'b1;
    @(negedge clk);

    // Test 1: back-to-back samples.
    start_q(0);
    check("t1_busy", busy8, 1'b1);
    for (int n = 0; n < 8; n++) send(0, ref_vec[n], 0);
    check("t1_lat_valid", ovalid8, 1'b0);
    check("t1_lat_busy", busy8, 1'b1);
    drain(0, "t1");
    check("t1_latency", lat, 1);
    expect_ref("t1");

    // Test 2: gapped valid.
    start_q(0);
    for (int n = 0; n < 8; n++) send(0, ref_vec[n], (n == 7) ? 0 : $urandom_range(0, 3));
    drain(0, "t2");
    expect_ref("t2");

    // Test 3: fewer samples than K.
    start_q(1);
    send(1, 7, 0);
    send(1, 3, 0);
    drain(1, "t3");
    expect_entry("t3", 0, 3, 1, 1'b1);
    expect_entry("t3", 1, 7, 0, 1'b1);
    expect_entry("t3", 2, ONES, 0, 1'b0);
    expect_entry("t3", 3, ONES, 0, 1'b0);

    // Test 4: all ties.
    start_q(0);
    for (int n = 0; n < 8; n++) send(0, 100, 0);
    drain(0, "t4");
    for (int r = 0; r < K; r++) expect_entry("t4", r, 100, IW'(r), 1'b1);

    // Test 5a: restart after three samples.
    start_q(0);
    for (int n = 0; n < 3; n++) send(0, 1, 0);
    start_q(0);
    for (int n = 0; n < 8; n++) send(0, ref_vec[n], 0);
    drain(0, "t5a");
    expect_ref("t5a");

    // Test 5b: valid coincident with start is dropped.
    start8 = 1'b1; valid8 = 1'b1; dist8 = 0;
    @(negedge clk);
    start8 = 1'b0; valid8 = 1'b0;
    for (int n = 0; n < 8; n++) send(0, ref_vec[n], 0);
    drain(0, "t5b");
    expect_ref("t5b");

    // Test 6: asynchronous reset mid-drain, then stray valid.
    start_q(0);
    for (int n = 0; n < 8; n++) send(0, ref_vec[n], 0);
    @(negedge clk);
    @(negedge clk);
    check("t6_rank1", orank8, 1);
    rst = 1'b0;
    #1;
    check("t6_valid", ovalid8, 1'b0);
    check("t6_done", done8, 1'b0);
    check("t6_busy", busy8, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send(0, 5, 1);
    check("t6_idle_busy", busy8, 1'b0);
    check("t6_idle_valid", ovalid8, 1'b0);
    check("t6_slot_empty", dut8.entry[0].filled, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
